// File: rtl/dmem_if.sv
// DMem bus between the single-cycle core and the data-memory responder.
interface dmem_if;
  logic        ena;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        w;
  logic        r;
  logic [1:0]  sel;
  logic [31:0] rdata;
  logic        ready;
  logic        acc_err;
  logic [7:0]  err_cnt;

  modport master (
    output ena, addr, wdata, w, r, sel,
    input  rdata, ready, acc_err, err_cnt
  );

  modport slave (
    input  ena, addr, wdata, w, r, sel,
    output rdata, ready, acc_err, err_cnt
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: combinational lane-justified loads, byte-lane stores,
// post-reset zero-fill of the RAM and a saturating access-error counter.
//
//   state | meaning
//   CLEAR | zero-filling mem[clr_idx], one word per cycle; core requests ignored
//   IDLE  | serving loads and stores until the next reset
module dmem_responder #(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] ADDR_BASE  = 32'h10010000,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);

  typedef enum logic {CLEAR, IDLE} state_t;
  localparam state_t RST_STATE = INIT_CLEAR ? CLEAR : IDLE;

  state_t        state, state_nx;
  logic [AW-1:0] clr_idx;
  logic [31:0]   mem [DEPTH];

  logic [31:0]   off;
  logic          in_window;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          idle;
  logic          misaligned;
  logic          acc_err;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   word;
  logic [7:0]    err_cnt;

  assign off       = bus.addr - ADDR_BASE;
  assign in_window = off < WIN_BYTES;
  assign idx       = off[AW+1:2];
  assign lane      = off[1:0];
  assign idle      = (state == IDLE);

  // Illegal sel is folded into misaligned so acc_err has a single term for it.
  always_comb begin
    misaligned = 1'b0;
    be         = 4'b0000;
    wlane      = bus.wdata;
    case (bus.sel)
      2'b11: begin
        misaligned = (lane != 2'b00);
        be         = 4'b1111;
      end
      2'b01: begin
        misaligned = lane[0];
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wlane      = {2{bus.wdata[15:0]}};
      end
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{bus.wdata[7:0]}};
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign acc_err = (bus.w | bus.r) & idle & (~in_window | misaligned);
  assign we      = bus.ena & bus.w & idle & ~acc_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RST_STATE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_idx == AW'(DEPTH - 1)) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
  end

  // RAM has no reset; CLEAR owns the write port until it hands over to IDLE.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign word = mem[idx];

  always_comb begin
    bus.rdata = '0;
    if (idle && in_window && bus.r) begin
      case (bus.sel)
        2'b01:   bus.rdata = {16'b0, lane[1] ? word[31:16] : word[15:0]};
        2'b00:   bus.rdata = {24'b0, word[8*lane +: 8]};
        default: bus.rdata = word;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           err_cnt <= '0;
    else if (acc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

  assign bus.acc_err = acc_err;
  assign bus.err_cnt = err_cnt;
  assign bus.ready   = idle;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a random
// mix of loads/stores checked against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          BYTES = 4096;

  logic clk;
  logic reset;
  dmem_if bus ();

  dmem_responder #(.DEPTH(1024), .ADDR_BASE(BASE), .INIT_CLEAR(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [7:0] mb [BYTES];
  int         m_err;
  bit         m_ready;

  function automatic bit m_accerr(logic w, logic r, logic [1:0] sel, logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (!(w || r) || !m_ready) return 1'b0;
    if (off >= BYTES) return 1'b1;
    if (sel == 2'b10) return 1'b1;
    if (sel == 2'b11 && (off % 4) != 0) return 1'b1;
    if (sel == 2'b01 && (off % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_rdata(logic r, logic [1:0] sel, logic [31:0] a);
    logic [31:0] off;
    int p;
    off = a - BASE;
    if (!r || !m_ready || off >= BYTES) return 32'h0;
    if (sel == 2'b01) begin
      p = int'(off) & ~1;
      return {16'h0, mb[p+1], mb[p]};
    end
    if (sel == 2'b00) begin
      p = int'(off);
      return {24'h0, mb[p]};
    end
    p = int'(off) & ~3;
    return {mb[p+3], mb[p+2], mb[p+1], mb[p]};
  endfunction

  task automatic apply(input logic e, input logic w, input logic r,
                       input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.ena = e; bus.w = w; bus.r = r; bus.sel = sel; bus.addr = a; bus.wdata = d;
    #1;
  endtask

  // Advance one edge, committing the held request into the reference model.
  task automatic tick();
    bit err;
    logic [31:0] off;
    int n;
    err = m_accerr(bus.w, bus.r, bus.sel, bus.addr);
    if (m_ready) begin
      if (err && m_err < 255) m_err++;
      if (bus.ena && bus.w && !err) begin
        off = bus.addr - BASE;
        n = (bus.sel == 2'b11) ? 4 : (bus.sel == 2'b01) ? 2 : 1;
        for (int i = 0; i < n; i++) mb[int'(off) + i] = bus.wdata[8*i +: 8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic measure_clear(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    m_ready = 1'b1;
    m_err   = 0;
    for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
  endtask

  task automatic test_reset();
    int n;
    bus.ena = 1'b1; bus.w = 1'b0; bus.r = 1'b1; bus.sel = 2'b11;
    bus.addr = BASE; bus.wdata = 32'h0;
    reset = 1'b1;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %h want 0", bus.ready); end
    vectors++;
    if (bus.err_cnt !== 8'h00) begin miscompares++; $display("FAIL reset_err_cnt got %h want 00", bus.err_cnt); end
    vectors++;
    if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
    vectors++;
    if (bus.acc_err !== 1'b0) begin miscompares++; $display("FAIL reset_acc_err got %h want 0", bus.acc_err); end
    @(negedge clk);
    reset = 1'b0;
    bus.r = 1'b0;
    #1;
    measure_clear(n);
    vectors++;
    if (n != 1024) begin miscompares++; $display("FAIL clear_cycles got %0d want 1024", n); end
    apply(1, 0, 1, 2'b11, 32'h10010FFC, 0);
    vectors++;
    if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL top_word_zero got %h want 0", bus.rdata); end
    tick();
  endtask

  task automatic test_byte_lanes();
    apply(1, 1, 0, 2'b11, 32'h10010008, 32'hDEADBEEF); tick();
    apply(1, 1, 0, 2'b00, 32'h1001000A, 32'hFFFFFF5A); tick();
    apply(1, 0, 1, 2'b11, 32'h10010008, 0);
    vectors++;
    if (bus.rdata !== 32'hDE5ABEEF) begin miscompares++; $display("FAIL word_after_byte got %h want DE5ABEEF", bus.rdata); end
    tick();
    apply(1, 0, 1, 2'b00, 32'h1001000B, 0);
    vectors++;
    if (bus.rdata !== 32'h000000DE) begin miscompares++; $display("FAIL byte_lane3 got %h want 000000DE", bus.rdata); end
    tick();
    apply(1, 0, 1, 2'b01, 32'h10010008, 0);
    vectors++;
    if (bus.rdata !== 32'h0000BEEF) begin miscompares++; $display("FAIL half_lane0 got %h want 0000BEEF", bus.rdata); end
    tick();
    // Simultaneous store and load: old data now, new data next cycle.
    apply(1, 1, 1, 2'b01, 32'h1001000A, 32'h00007777);
    vectors++;
    if (bus.rdata !== 32'h0000DE5A) begin miscompares++; $display("FAIL wr_same_cycle got %h want 0000DE5A", bus.rdata); end
    tick();
    apply(1, 0, 1, 2'b11, 32'h10010008, 0);
    vectors++;
    if (bus.rdata !== 32'h7777BEEF) begin miscompares++; $display("FAIL wr_next_cycle got %h want 7777BEEF", bus.rdata); end
    tick();
  endtask

  task automatic test_misaligned();
    apply(1, 1, 0, 2'b01, 32'h10010011, 32'h00001234);
    vectors++;
    if (bus.acc_err !== 1'b1) begin miscompares++; $display("FAIL misaligned_half_err got %h want 1", bus.acc_err); end
    tick();
    vectors++;
    if (bus.err_cnt !== 8'd1) begin miscompares++; $display("FAIL misaligned_err_cnt got %0d want 1", bus.err_cnt); end
    apply(1, 0, 1, 2'b11, 32'h10010010, 0);
    vectors++;
    if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL misaligned_no_write got %h want 0", bus.rdata); end
    tick();
  endtask

  task automatic test_out_of_window();
    apply(1, 1, 1, 2'b11, 32'h10011000, 32'hA5A5A5A5);
    vectors++;
    if (bus.acc_err !== 1'b1) begin miscompares++; $display("FAIL oow_err got %h want 1", bus.acc_err); end
    vectors++;
    if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL oow_rdata got %h want 0", bus.rdata); end
    tick();
    apply(1, 0, 1, 2'b10, 32'h10010008, 0);
    vectors++;
    if (bus.acc_err !== 1'b1) begin miscompares++; $display("FAIL illegal_sel_err got %h want 1", bus.acc_err); end
    tick();
    vectors++;
    if (bus.err_cnt !== 8'd3) begin miscompares++; $display("FAIL oow_err_cnt got %0d want 3", bus.err_cnt); end
    apply(1, 0, 1, 2'b11, 32'h10010000, 0);
    vectors++;
    if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL oow_no_wrap_write got %h want 0", bus.rdata); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp_rd;
    logic [1:0]  s;
    logic        w, r, e;
    bit          exp_err;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1, 2:    a = BASE + $urandom_range(4000, 4200);
        default: a = BASE + $urandom_range(0, 63);
      endcase
      s = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) != 0);
      d = $urandom;
      apply(e, w, r, s, a, d);
      exp_err = m_accerr(w, r, s, a);
      exp_rd  = m_rdata(r, s, a);
      vectors++;
      if (bus.acc_err !== exp_err) begin
        miscompares++;
        $display("FAIL rand_acc_err addr=%h sel=%b w=%b r=%b got %h want %h", a, s, w, r, bus.acc_err, exp_err);
      end
      if (!(r && s == 2'b10)) begin
        vectors++;
        if (bus.rdata !== exp_rd) begin
          miscompares++;
          $display("FAIL rand_rdata addr=%h sel=%b r=%b got %h want %h", a, s, r, bus.rdata, exp_rd);
        end
      end
      tick();
      vectors++;
      if (bus.err_cnt !== 8'(m_err)) begin
        miscompares++;
        $display("FAIL rand_err_cnt got %0d want %0d", bus.err_cnt, m_err);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    apply(1, 1, 0, 2'b11, 32'h10010040, 32'h13572468); tick();
    apply(1, 1, 0, 2'b11, 32'h10010FFC, 32'h89ABCDEF); tick();
    @(negedge clk);
    bus.w = 1'b0; bus.r = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    measure_clear(n);
    vectors++;
    if (n != 1024) begin miscompares++; $display("FAIL mid_clear_cycles got %0d want 1024", n); end
    vectors++;
    if (bus.err_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_clear_err_cnt got %0d want 0", bus.err_cnt); end
    apply(1, 0, 1, 2'b11, 32'h10010040, 0);
    vectors++;
    if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL mid_clear_low_word got %h want 0", bus.rdata); end
    tick();
    apply(1, 0, 1, 2'b11, 32'h10010FFC, 0);
    vectors++;
    if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL mid_clear_top_word got %h want 0", bus.rdata); end
    tick();
  endtask

  task automatic test_ena_and_saturate();
    apply(1, 1, 0, 2'b11, 32'h10010020, 32'hCAFEF00D); tick();
    apply(0, 1, 0, 2'b11, 32'h10010020, 32'h11111111); tick();
    apply(0, 1, 0, 2'b00, 32'h10010021, 32'h00000099); tick();
    apply(1, 0, 1, 2'b11, 32'h10010020, 0);
    vectors++;
    if (bus.rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL ena_blocks_write got %h want CAFEF00D", bus.rdata); end
    tick();
    for (int i = 0; i < 260; i++) begin
      apply(1, 0, 1, 2'b10, BASE + 32'(4 * $urandom_range(0, 15)), 0);
      tick();
    end
    vectors++;
    if (bus.err_cnt !== 8'hFF) begin miscompares++; $display("FAIL err_cnt_saturate got %h want FF", bus.err_cnt); end
    vectors++;
    if (m_err != 255) begin miscompares++; $display("FAIL model_saturate got %0d want 255", m_err); end
    apply(1, 0, 0, 2'b11, BASE, 0);
    tick();
    vectors++;
    if (bus.err_cnt !== 8'hFF) begin miscompares++; $display("FAIL err_cnt_hold got %h want FF", bus.err_cnt); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_byte_lanes();
    test_misaligned();
    test_out_of_window();
    test_random();
    test_reset_mid_clear();
    test_ena_and_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle MIPS core's DMem interface.
- Accepts word, halfword and byte loads and stores in one CPU cycle.
  - Stores commit at posedge clk.
  - Loads are combinational, with the addressed lane right-justified so the core does sign or zero extension.
- Zero-fills its RAM with an FSM after every reset, because an async reset cannot clear an array.
- Flags misaligned and out-of-window accesses and keeps a saturating error count for debug.

Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of 2.
- ADDR_BASE, 32'h10010000: byte address of word 0 (MARS data segment).
- INIT_CLEAR, 1: 1 = run the zero-fill FSM after reset; 0 = go to IDLE immediately, RAM contents undefined.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state registers.
- ena  in  1  0 blocks all writes; reads and flags still evaluate.
- addr  in  32  byte address (core ALU result).
- wdata  in  32  store data; the lane source is always wdata[7:0], wdata[15:0] or wdata[31:0].
- w  in  1  store request.
- r  in  1  load request.
- sel  in  2  size: 2'b11 word, 2'b01 half, 2'b00 byte, 2'b10 illegal.
- rdata  out  32  load data, right-justified, upper bits zero.
- ready  out  1  1 in IDLE; 0 during CLEAR.
- acc_err  out  1  combinational; current access (w|r) is misaligned, out of window or illegal sel.
- err_cnt  out  8  registered saturating count of erroneous accesses.

Behaviour:
Reset values:
- state = CLEAR if INIT_CLEAR, else IDLE.
- clr_idx = 0, err_cnt = 0.
- ready = 0 when INIT_CLEAR, else 1.
- rdata = 0 (forced while in CLEAR).
- RAM is not reset.

Address decode:
- off = addr - ADDR_BASE (32-bit, wrapping).
- in_window = off < DEPTH*4.
- idx = off[log2(DEPTH)+1:2].
- lane = off[1:0].

Alignment:
- Word: lane == 0.
- Half: lane[0] == 0.
- Byte: any lane.
- sel == 2'b10 is always an error.
- acc_err = (w|r) & state==IDLE & (!in_window | misaligned | sel==2'b10).

FSM CLEAR:
- Each cycle: mem[clr_idx] <= 0; clr_idx <= clr_idx + 1.
- When clr_idx == DEPTH-1, go to IDLE at the same edge. CLEAR therefore lasts exactly DEPTH cycles; ready rises on the next cycle.
- Core w/r are ignored: no write, rdata = 0, acc_err = 0, err_cnt unchanged.
- Reset asserted mid-CLEAR restarts the FSM at clr_idx = 0.

FSM IDLE:
- Stays in IDLE until reset.

Stores (at posedge, when ena & w & state==IDLE & !acc_err):
- Little-endian byte-lane write.
  - Word: mem[idx] <= wdata.
  - Half: mem[idx] bytes {lane+1, lane} <= wdata[15:0].
  - Byte: byte lane <= wdata[7:0].
- Untouched lanes are preserved.
- An erroneous store writes nothing.

Loads (combinational, when state==IDLE & in_window):
- Word: rdata = mem[idx].
- Half: rdata = {16'b0, halfword at lane}.
- Byte: rdata = {24'b0, byte at lane}.
- Out of window: rdata = 0.
- Misaligned load: still returns the lane data (lane[1] selects the half; a word ignores lane) and asserts acc_err.
- rdata depends on the r input.

Simultaneous w & r:
- rdata shows pre-write contents.
- The write commits at the edge.
- A new value is visible the cycle after the write.

err_cnt:
- Increments at posedge when acc_err.
- Saturates at 8'hFF.

Timing:
- Load latency 0 cycles.
- Store latency 1 edge.
- No stalls and no handshake beyond ready; the core must hold off until ready.

Test Plan:
1. Reset, then hold 1023 cycles -> ready == 0 throughout. After cycle 1024 -> ready == 1. Word load of 0x10010FFC -> 32'h0.
2. Word store 32'hDEADBEEF to 0x10010008, then byte store 8'h5A to 0x1001000A -> word load reads 32'hDE5ABEEF. Byte load 0x1001000B -> 32'h000000DE. Half load 0x10010008 -> 32'h0000BEEF.
3. Half store 16'h1234 to 0x10010011 (misaligned) -> acc_err = 1, word 0x10010010 unchanged (0), err_cnt = 1.
4. Store to 0x10011000 (out of window) and sel = 2'b10 load -> acc_err = 1 each time, rdata = 0 for the out-of-window access, no RAM change, err_cnt increments by 2.
5. Assert reset 300 cycles into CLEAR -> ready stays 0 for a further DEPTH = 1024 cycles. Words written before reset read 0.
6. Store with ena = 0 -> no change. 260 consecutive erroneous cycles -> err_cnt holds at 8'hFF.
